wb_regfile: RTL and testbench

- Write-back end of the MEM-stage interface.
- Captures the MEM stage's GPR and HI/LO write requests in a MEM/WB pipeline latch, then commits them into a 32-entry general register file and the HI/LO pair.
- Provides two GPR read ports and a HI/LO read port to the decode and execute stages, with write-back bypass, so consumers see the committing value in the same cycle.

---
 rtl/wb_regfile_pkg.sv | 19 +
 rtl/wb_latch.sv | 52 +++++
 rtl/wb_regfile.sv | 113 +++++++++++
 tb/tb_wb_regfile.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_regfile_pkg.sv
// Shared constants for the MEM/WB latch and the write-back register file.
// Default bus widths and the enable/zero encodings used on both sides of the latch.
package wb_regfile_pkg;

  localparam int RegBusW     = 32;
  localparam int RegAddrBusW = 5;
  localparam int RegNum      = 32;

  localparam logic RstEnable    = 1'b1;
  localparam logic WriteEnable  = 1'b1;
  localparam logic WriteDisable = 1'b0;

  localparam logic [RegBusW-1:0]     ZeroWord   = '0;
  localparam logic [RegAddrBusW-1:0] NOPRegAddr = '0;

  // r0 is hardwired to zero; writes to it are discarded everywhere.
  localparam int RegZero = 0;

endpackage

// File: rtl/wb_latch.sv
// MEM/WB pipeline register: captures the MEM-stage write request.
// Flush loads a bubble and takes priority over stall, which holds the entry.
module wb_latch
  import wb_regfile_pkg::*;
#(
  parameter int DATA_W = RegBusW,
  parameter int ADDR_W = RegAddrBusW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic [ADDR_W-1:0] mem_wd,
  input  logic              mem_wreg,
  input  logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_hi,
  input  logic [DATA_W-1:0] mem_lo,
  input  logic              mem_whilo,
  output logic [ADDR_W-1:0] wb_wd,
  output logic              wb_wreg,
  output logic [DATA_W-1:0] wb_wdata,
  output logic [DATA_W-1:0] wb_hi,
  output logic [DATA_W-1:0] wb_lo,
  output logic              wb_whilo
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst == RstEnable) begin
      wb_wd    <= ADDR_W'(NOPRegAddr);
      wb_wreg  <= WriteDisable;
      wb_wdata <= DATA_W'(ZeroWord);
      wb_hi    <= DATA_W'(ZeroWord);
      wb_lo    <= DATA_W'(ZeroWord);
      wb_whilo <= WriteDisable;
    end else if (flush) begin
      wb_wd    <= ADDR_W'(NOPRegAddr);
      wb_wreg  <= WriteDisable;
      wb_wdata <= DATA_W'(ZeroWord);
      wb_hi    <= DATA_W'(ZeroWord);
      wb_lo    <= DATA_W'(ZeroWord);
      wb_whilo <= WriteDisable;
    end else if (!stall) begin
      wb_wd    <= mem_wd;
      wb_wreg  <= mem_wreg;
      wb_wdata <= mem_wdata;
      wb_hi    <= mem_hi;
      wb_lo    <= mem_lo;
      wb_whilo <= mem_whilo;
    end
  end

endmodule

// File: rtl/wb_regfile.sv
// Write-back stage: MEM/WB latch, 32-entry GPR file with HI/LO, and read ports
// that bypass the committing entry so consumers see it in the same cycle.
module wb_regfile
  import wb_regfile_pkg::*;
#(
  parameter int DATA_W  = RegBusW,
  parameter int ADDR_W  = RegAddrBusW,
  parameter int REG_NUM = RegNum
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic [ADDR_W-1:0] mem_wd,
  input  logic              mem_wreg,
  input  logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_hi,
  input  logic [DATA_W-1:0] mem_lo,
  input  logic              mem_whilo,
  input  logic              re1,
  input  logic [ADDR_W-1:0] raddr1,
  output logic [DATA_W-1:0] rdata1,
  input  logic              re2,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata2,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o,
  output logic [ADDR_W-1:0] wb_wd,
  output logic              wb_wreg,
  output logic              wb_whilo
);

  logic [DATA_W-1:0] wb_wdata;
  logic [DATA_W-1:0] wb_hi;
  logic [DATA_W-1:0] wb_lo;
  logic [DATA_W-1:0] gpr_reg [REG_NUM];
  logic [DATA_W-1:0] hi_reg;
  logic [DATA_W-1:0] lo_reg;
  logic              gpr_we;

  wb_latch #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_wb_latch (
    .clk       (clk),
    .rst       (rst),
    .stall     (stall),
    .flush     (flush),
    .mem_wd    (mem_wd),
    .mem_wreg  (mem_wreg),
    .mem_wdata (mem_wdata),
    .mem_hi    (mem_hi),
    .mem_lo    (mem_lo),
    .mem_whilo (mem_whilo),
    .wb_wd     (wb_wd),
    .wb_wreg   (wb_wreg),
    .wb_wdata  (wb_wdata),
    .wb_hi     (wb_hi),
    .wb_lo     (wb_lo),
    .wb_whilo  (wb_whilo)
  );

  // A latched write to r0 is treated as no write at all, for both array and bypass.
  assign gpr_we = (wb_wreg == WriteEnable) && (wb_wd != ADDR_W'(RegZero));

  always_ff @(posedge clk or posedge rst) begin
    if (rst == RstEnable) begin
      for (int i = 0; i < REG_NUM; i++) begin
        gpr_reg[i] <= '0;
      end
    end else if (gpr_we) begin
      gpr_reg[wb_wd] <= wb_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst == RstEnable) begin
      hi_reg <= '0;
      lo_reg <= '0;
    end else if (wb_whilo == WriteEnable) begin
      hi_reg <= wb_hi;
      lo_reg <= wb_lo;
    end
  end

  function automatic logic [DATA_W-1:0] rd_mux(
    input logic              rd_en,
    input logic [ADDR_W-1:0] rd_addr,
    input logic [DATA_W-1:0] arr_val
  );
    if (!rd_en || rd_addr == ADDR_W'(RegZero)) begin
      return '0;
    end else if (gpr_we && rd_addr == wb_wd) begin
      return wb_wdata;
    end
    return arr_val;
  endfunction

  // Outputs are forced to zero for the whole time reset is held.
  always_comb begin
    rdata1 = '0;
    rdata2 = '0;
    hi_o   = '0;
    lo_o   = '0;
    if (rst != RstEnable) begin
      rdata1 = rd_mux(re1, raddr1, gpr_reg[raddr1]);
      rdata2 = rd_mux(re2, raddr2, gpr_reg[raddr2]);
      hi_o   = (wb_whilo == WriteEnable) ? wb_hi : hi_reg;
      lo_o   = (wb_whilo == WriteEnable) ? wb_lo : lo_reg;
    end
  end

endmodule

// File: tb/tb_wb_regfile.sv
// Randomized and directed checks of wb_regfile against a request-level model
// of the MEM/WB entry, the register file and HI/LO.
module tb_wb_regfile;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall, flush;
  logic [4:0]  mem_wd;
  logic        mem_wreg;
  logic [31:0] mem_wdata, mem_hi, mem_lo;
  logic        mem_whilo;
  logic        re1, re2;
  logic [4:0]  raddr1, raddr2;
  logic [31:0] rdata1, rdata2, hi_o, lo_o;
  logic [4:0]  wb_wd;
  logic        wb_wreg, wb_whilo;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Reference model: architectural state plus the one pending request.
  logic [31:0] m_gpr [32];
  logic [31:0] m_hi, m_lo;
  logic [4:0]  p_wd;
  logic        p_wreg, p_whilo;
  logic [31:0] p_wdata, p_hi, p_lo;

  wb_regfile dut (
    .clk       (clk),
    .rst       (rst),
    .stall     (stall),
    .flush     (flush),
    .mem_wd    (mem_wd),
    .mem_wreg  (mem_wreg),
    .mem_wdata (mem_wdata),
    .mem_hi    (mem_hi),
    .mem_lo    (mem_lo),
    .mem_whilo (mem_whilo),
    .re1       (re1),
    .raddr1    (raddr1),
    .rdata1    (rdata1),
    .re2       (re2),
    .raddr2    (raddr2),
    .rdata2    (rdata2),
    .hi_o      (hi_o),
    .lo_o      (lo_o),
    .wb_wd     (wb_wd),
    .wb_wreg   (wb_wreg),
    .wb_whilo  (wb_whilo)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_gpr[i] = '0;
    m_hi = '0; m_lo = '0;
    p_wd = '0; p_wreg = 1'b0; p_whilo = 1'b0;
    p_wdata = '0; p_hi = '0; p_lo = '0;
  endtask

  // What a consumer should see for a GPR right now: newest pending write, else stored.
  function automatic logic [31:0] exp_read(input logic en, input logic [4:0] a);
    if (rst || !en || a == 5'd0) return 32'd0;
    if (p_wreg && p_wd == a) return p_wdata;
    return m_gpr[a];
  endfunction

  task automatic model_edge();
    if (p_wreg && p_wd != 5'd0) m_gpr[p_wd] = p_wdata;
    if (p_whilo) begin
      m_hi = p_hi;
      m_lo = p_lo;
    end
    if (flush) begin
      p_wd = '0; p_wreg = 1'b0; p_whilo = 1'b0;
      p_wdata = '0; p_hi = '0; p_lo = '0;
    end else if (!stall) begin
      p_wd = mem_wd; p_wreg = mem_wreg; p_whilo = mem_whilo;
      p_wdata = mem_wdata; p_hi = mem_hi; p_lo = mem_lo;
    end
  endtask

  task automatic check_outputs();
    check_val("rdata1", rdata1, exp_read(re1, raddr1));
    check_val("rdata2", rdata2, exp_read(re2, raddr2));
    check_val("hi_o", hi_o, rst ? 32'd0 : (p_whilo ? p_hi : m_hi));
    check_val("lo_o", lo_o, rst ? 32'd0 : (p_whilo ? p_lo : m_lo));
    check_val("wb_wd", 32'(wb_wd), 32'(p_wd));
    check_val("wb_wreg", 32'(wb_wreg), 32'(p_wreg));
    check_val("wb_whilo", 32'(wb_whilo), 32'(p_whilo));
  endtask

  task automatic set_mem(input logic [4:0] wd, input logic wreg, input logic [31:0] wdata,
                         input logic [31:0] hi, input logic [31:0] lo, input logic whilo);
    mem_wd = wd; mem_wreg = wreg; mem_wdata = wdata;
    mem_hi = hi; mem_lo = lo; mem_whilo = whilo;
  endtask

  task automatic set_rd(input logic e1, input logic [4:0] a1, input logic e2, input logic [4:0] a2);
    re1 = e1; raddr1 = a1; re2 = e2; raddr2 = a2;
  endtask

  // Called just after a falling edge with inputs set; checks, then crosses one rising edge.
  task automatic do_cycle();
    #1;
    check_outputs();
    $display("cyc=%0d rst=%0b stall=%0b flush=%0b mem_wd=%0d wreg=%0b wdata=%h whilo=%0b | rd1[%0d]=%h rd2[%0d]=%h hi=%h lo=%h",
             cyc, rst, stall, flush, mem_wd, mem_wreg, mem_wdata, mem_whilo,
             raddr1, rdata1, raddr2, rdata2, hi_o, lo_o);
    @(posedge clk);
    if (!rst) model_edge();
    @(negedge clk);
    cyc++;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    set_mem(5'd0, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0);
    set_rd(1'b1, 5'd1, 1'b1, 5'd2);
    model_reset();
    @(negedge clk);
    do_cycle();
    rst = 1'b0;

    // Fill every GPR and HI/LO, then reset asynchronously in the middle of a cycle.
    for (int i = 1; i < 32; i++) begin
      set_mem(5'(i), 1'b1, 32'h0101_0101 * i, 32'hCAFE_0000, 32'h0000_F00D, i == 31);
      do_cycle();
    end
    set_mem(5'd0, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0);
    do_cycle();
    set_rd(1'b1, 5'd3, 1'b1, 5'd31);
    #1;
    check_val("prewrite_r3", rdata1, 32'h0303_0303);
    check_val("prewrite_hi", hi_o, 32'hCAFE_0000);
    #1;
    rst = 1'b1;
    model_reset();
    #1;
    check_val("async_rst_rd1", rdata1, 32'd0);
    check_val("async_rst_rd2", rdata2, 32'd0);
    check_val("async_rst_hi", hi_o, 32'd0);
    check_val("async_rst_lo", lo_o, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 1; i < 32; i++) begin
      set_rd(1'b1, 5'(i), 1'b1, 5'(32 - i));
      #1;
      check_val($sformatf("post_rst_r%0d", i), rdata1, 32'd0);
      do_cycle();
    end

    // r5 via bypass, then from the array.
    set_mem(5'd5, 1'b1, 32'hDEAD_BEEF, 32'd0, 32'd0, 1'b0);
    set_rd(1'b1, 5'd5, 1'b1, 5'd5);
    do_cycle();
    set_mem(5'd0, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0);
    #1;
    check_val("bypass_r5", rdata1, 32'hDEAD_BEEF);
    check_val("bypass_r5_p2", rdata2, 32'hDEAD_BEEF);
    do_cycle();
    #1;
    check_val("array_r5", rdata1, 32'hDEAD_BEEF);
    do_cycle();

    // Writes to r0 never become visible.
    set_mem(5'd0, 1'b1, 32'h0000_1234, 32'd0, 32'd0, 1'b0);
    set_rd(1'b1, 5'd0, 1'b1, 5'd0);
    do_cycle();
    set_mem(5'd0, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0);
    #1;
    check_val("r0_bypass", rdata1, 32'd0);
    do_cycle();
    #1;
    check_val("r0_array", rdata1, 32'd0);
    do_cycle();

    // HI/LO together with a GPR write to r7.
    set_mem(5'd7, 1'b1, 32'h0000_0077, 32'hAAAA_0000, 32'h0000_BBBB, 1'b1);
    set_rd(1'b1, 5'd7, 1'b0, 5'd7);
    do_cycle();
    set_mem(5'd0, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0);
    #1;
    check_val("hilo_byp_hi", hi_o, 32'hAAAA_0000);
    check_val("hilo_byp_lo", lo_o, 32'h0000_BBBB);
    check_val("hilo_byp_r7", rdata1, 32'h0000_0077);
    check_val("re2_off", rdata2, 32'd0);
    do_cycle();
    do_cycle();
    #1;
    check_val("hilo_keep_hi", hi_o, 32'hAAAA_0000);
    check_val("hilo_keep_lo", lo_o, 32'h0000_BBBB);
    check_val("hilo_keep_r7", rdata1, 32'h0000_0077);

    // Stall holds r3=0x11 while r4=0x22 waits on the MEM side.
    set_mem(5'd3, 1'b1, 32'h0000_0011, 32'd0, 32'd0, 1'b0);
    do_cycle();
    stall = 1'b1;
    set_mem(5'd4, 1'b1, 32'h0000_0022, 32'd0, 32'd0, 1'b0);
    set_rd(1'b1, 5'd4, 1'b1, 5'd3);
    for (int i = 0; i < 3; i++) begin
      #1;
      check_val($sformatf("stall_r4_%0d", i), rdata1, 32'd0);
      check_val($sformatf("stall_r3_%0d", i), rdata2, 32'h0000_0011);
      do_cycle();
    end
    stall = 1'b0;
    do_cycle();
    #1;
    check_val("unstall_r4", rdata1, 32'h0000_0022);
    set_mem(5'd0, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0);
    do_cycle();

    // Flush wins over stall: the r9=0x99 request becomes a bubble.
    set_mem(5'd9, 1'b1, 32'h0000_0055, 32'd0, 32'd0, 1'b0);
    set_rd(1'b1, 5'd9, 1'b0, 5'd0);
    do_cycle();
    set_mem(5'd9, 1'b1, 32'h0000_0099, 32'd0, 32'd0, 1'b0);
    stall = 1'b1; flush = 1'b1;
    do_cycle();
    stall = 1'b0; flush = 1'b0;
    set_mem(5'd0, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0);
    #1;
    check_val("flush_wreg", 32'(wb_wreg), 32'd0);
    check_val("flush_r9_old", rdata1, 32'h0000_0055);
    do_cycle();
    #1;
    check_val("flush_r9_array", rdata1, 32'h0000_0055);

    // Random traffic, addresses mostly clustered to provoke bypass hits.
    for (int n = 0; n < 400; n++) begin
      stall = ($urandom_range(0, 3) == 0);
      flush = ($urandom_range(0, 9) == 0);
      set_mem(($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7)),
              $urandom_range(0, 3) != 0, $urandom, $urandom, $urandom, $urandom_range(0, 2) == 0);
      set_rd($urandom_range(0, 7) != 0, 5'($urandom_range(0, 7)),
             $urandom_range(0, 7) != 0, 5'($urandom_range(0, 7)));
      do_cycle();
    end
    stall = 1'b0; flush = 1'b0;
    set_mem(5'd0, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      set_rd(1'b1, 5'(i), 1'b1, 5'(i));
      do_cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
